// File: rtl/xsc_pkg.sv
// Shared definitions for the XOR splice self-checker.
//   form_e      : the four XOR-form variants of the reconstruction LSB
//   MAX_FORMS   : largest number of forms the checker supports
//   splice_lsb  : LSB produced by one XOR form from the slice end bits
//   lowest_form : index of the lowest set bit of a mismatch vector
package xsc_pkg;

  localparam int MAX_FORMS = 4;

  typedef enum logic [1:0] {
    FORM_HXH = 2'd0,  // x[HI] ^ x[LO] ^ x[HI]
    FORM_LHH = 2'd1,  // x[LO] ^ x[HI] ^ x[HI]
    FORM_0X0 = 2'd2,  // 0 ^ x[LO] ^ 0
    FORM_1X1 = 2'd3   // 1 ^ x[LO] ^ 1
  } form_e;

  // Every form reduces algebraically to lo; the point of the checker is to
  // catch a tool that simplifies one of these expressions incorrectly.
  function automatic logic splice_lsb(form_e form, logic hi, logic lo);
    case (form)
      FORM_HXH: splice_lsb = hi ^ lo ^ hi;
      FORM_LHH: splice_lsb = lo ^ hi ^ hi;
      FORM_0X0: splice_lsb = 1'b0 ^ lo ^ 1'b0;
      FORM_1X1: splice_lsb = 1'b1 ^ lo ^ 1'b1;
      default:  splice_lsb = lo;
    endcase
  endfunction

  function automatic logic [1:0] lowest_form(logic [MAX_FORMS-1:0] mis);
    lowest_form = 2'd0;
    for (int k = MAX_FORMS - 1; k >= 0; k--) begin
      if (mis[k]) lowest_form = 2'(k);
    end
  endfunction

endpackage

// File: rtl/xor_splice_checker_if.sv
// Sample-in / result-out handshake bundle of xor_splice_checker.
//   in_valid/in_ready/in_data       : sample stream into the checker
//   res_valid/res_ready/res_mismatch: per-sample result stream out
// Handshake: a transfer happens on a rising edge where valid & ready are both
// 1; a source holding valid=1 keeps its payload stable until that transfer.
// master = stimulus source / result sink, slave = the checker.
interface xor_splice_checker_if #(
  parameter int WIDTH     = 64,
  parameter int NUM_FORMS = 4
) ();
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_data;
  logic                 res_valid;
  logic                 res_ready;
  logic [NUM_FORMS-1:0] res_mismatch;

  modport master (
    output in_valid, in_data, res_ready,
    input  in_ready, res_valid, res_mismatch
  );

  modport slave (
    input  in_valid, in_data, res_ready,
    output in_ready, res_valid, res_mismatch
  );
endinterface

// File: rtl/xsc_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, reset_l : clock, synchronous active-low reset
//   clr          : zero the count (dominates inc)
//   inc          : add one unless already at all-ones
//   cnt          : current count
module xsc_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_l,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!reset_l) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/xor_splice_checker.sv
// Pipelined self-check of bit-slice splice expressions. Each accepted word x
// is rebuilt as {x[HI:LO+1], f_k(x)} for every enabled XOR form k and compared
// with x[HI:LO]; results are counted, flagged and the first failure captured.
//   clk, reset_l  : clock, synchronous active-low reset
//   bus (slave)   : sample in / result out handshakes
//   clear         : zero counters, sticky flag and capture (pipeline untouched)
//   sample_cnt    : retired samples, saturating
//   err_cnt       : per-form mismatch counts, form k at [k*CNT_W +: CNT_W]
//   err_sticky    : any retired mismatch since reset/clear
//   fail_valid/fail_data/fail_form : first failing sample and its lowest form
module xor_splice_checker
  import xsc_pkg::*;
#(
  parameter int                   WIDTH     = 64,
  parameter int                   HI        = 38,
  parameter int                   LO        = 31,
  parameter int                   NUM_FORMS = 4,
  parameter logic [MAX_FORMS-1:0] FORM_MASK = 4'hF,
  parameter int                   CNT_W     = 16
) (
  input  logic                       clk,
  input  logic                       reset_l,
  xor_splice_checker_if.slave        bus,
  input  logic                       clear,
  output logic [CNT_W-1:0]           sample_cnt,
  output logic [NUM_FORMS*CNT_W-1:0] err_cnt,
  output logic                       err_sticky,
  output logic                       fail_valid,
  output logic [WIDTH-1:0]           fail_data,
  output logic [1:0]                 fail_form
);

  logic                 w_en;
  logic                 w_retire;
  logic [NUM_FORMS-1:0] w_s1_mis;
  logic [NUM_FORMS-1:0] w_res_mismatch;
  logic [MAX_FORMS-1:0] w_mis_pad;

  logic                 r_s1_valid;
  logic [WIDTH-1:0]     r_s1_x;
  logic                 r_s2_valid;
  logic [NUM_FORMS-1:0] r_s2_mis;
  logic [WIDTH-1:0]     r_s2_x;
  logic                 r_err_sticky;
  logic                 r_fail_valid;
  logic [WIDTH-1:0]     r_fail_data;
  logic [1:0]           r_fail_form;

  // Single global enable: the whole pipe advances or the whole pipe holds,
  // which keeps res_* stable under backpressure without skid storage.
  assign w_en     = !r_s2_valid | bus.res_ready;
  assign w_retire = r_s2_valid & bus.res_ready;

  always_comb begin
    w_s1_mis = '0;
    for (int k = 0; k < NUM_FORMS; k++) begin
      w_s1_mis[k] = FORM_MASK[k] &
        ({r_s1_x[HI:LO+1], splice_lsb(form_e'(k[1:0]), r_s1_x[HI], r_s1_x[LO])}
          != r_s1_x[HI:LO]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_l) begin
      r_s1_valid <= 1'b0;
      r_s1_x     <= '0;
      r_s2_valid <= 1'b0;
      r_s2_mis   <= '0;
      r_s2_x     <= '0;
    end else if (w_en) begin
      r_s1_valid <= bus.in_valid;
      r_s1_x     <= bus.in_data;
      r_s2_valid <= r_s1_valid;
      // Bubbles carry a zero vector so an idle result never shows a mismatch.
      r_s2_mis   <= r_s1_valid ? w_s1_mis : '0;
      r_s2_x     <= r_s1_x;
    end
  end

  // All consumers of the result vector read this one net, so the counters,
  // sticky flag and capture always agree with what the sink observes.
  assign w_res_mismatch = r_s2_mis;
  assign w_mis_pad      = MAX_FORMS'(w_res_mismatch);

  assign bus.in_ready     = w_en;
  assign bus.res_valid    = r_s2_valid;
  assign bus.res_mismatch = w_res_mismatch;

  always_ff @(posedge clk) begin
    if (!reset_l) begin
      r_err_sticky <= 1'b0;
      r_fail_valid <= 1'b0;
      r_fail_data  <= '0;
      r_fail_form  <= 2'd0;
    end else if (clear) begin
      r_err_sticky <= 1'b0;
      r_fail_valid <= 1'b0;
      r_fail_data  <= '0;
      r_fail_form  <= 2'd0;
    end else if (w_retire && (|w_res_mismatch)) begin
      r_err_sticky <= 1'b1;
      if (!r_fail_valid) begin
        r_fail_valid <= 1'b1;
        r_fail_data  <= r_s2_x;
        r_fail_form  <= lowest_form(w_mis_pad);
      end
    end
  end

  assign err_sticky = r_err_sticky;
  assign fail_valid = r_fail_valid;
  assign fail_data  = r_fail_data;
  assign fail_form  = r_fail_form;

  xsc_sat_counter #(.CNT_W(CNT_W)) u_sample_cnt (
    .clk     (clk),
    .reset_l (reset_l),
    .clr     (clear),
    .inc     (w_retire),
    .cnt     (sample_cnt)
  );

  for (genvar g = 0; g < NUM_FORMS; g++) begin : g_err
    xsc_sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
      .clk     (clk),
      .reset_l (reset_l),
      .clr     (clear),
      .inc     (w_retire & w_res_mismatch[g]),
      .cnt     (err_cnt[g*CNT_W +: CNT_W])
    );
  end

endmodule
